// File: rtl/kiss_fsm_pkg.sv
// kiss_fsm_pkg: shared controller type, width helpers and entry packing for the table-driven FSM engine
package kiss_fsm_pkg;

    typedef enum logic {CFG, RUN} ctl_e;

    localparam int ENT_OUT_LSB = 0;

    function automatic int sw_f(input int n_state);
        return ($clog2(n_state) > 1) ? $clog2(n_state) : 1;
    endfunction

    function automatic int depth_f(input int n_state, input int n_in);
        return n_state << n_in;
    endfunction

    function automatic int ew_f(input int sw, input int n_out);
        return sw + n_out;
    endfunction

endpackage

// File: rtl/kiss_fsm_engine_table.sv
// kiss_fsm_table: transition/output storage, synchronous write and asynchronous read, no reset on contents
module kiss_fsm_table #(
    parameter int AW    = 5,
    parameter int DEPTH = 32,
    parameter int EW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [EW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [EW-1:0] rdata
);

    logic [EW-1:0] mem [DEPTH];

    // Table entry write during configuration
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];

endmodule

// File: rtl/kiss_fsm_engine.sv
// kiss_fsm_engine: RAM-loaded Mealy FSM engine; optional toggle-activity counter under FSM_ACTIVITY_CNT_EN
module kiss_fsm_engine
    import kiss_fsm_pkg::*;
#(
    parameter int N_IN      = 2,
    parameter int N_OUT     = 3,
    parameter int N_STATE   = 8,
    parameter int RST_STATE = 0,
    localparam int SW       = sw_f(N_STATE)
) (
    input  logic              clk,
    input  logic              rst,
`ifdef FSM_ACTIVITY_CNT_EN
    input  logic              act_clr,
    output logic [31:0]       act_count,
`endif
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [SW+N_OUT-1:0] cfg_data,
    input  logic              cfg_restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_OUT-1:0]  out_data,
    output logic [SW-1:0]     out_state,
    output logic              running,
    output logic              err
);

    localparam int DEPTH = depth_f(N_STATE, N_IN);
    localparam int AW    = SW + N_IN;
    localparam int EW    = ew_f(SW, N_OUT);
    localparam logic [SW-1:0] RST_S = SW'(RST_STATE);
    // One bit per encodable state code, set where the code names a real state
    localparam logic [(1<<SW)-1:0] LEGAL = {(1<<SW){1'b1}} >> ((1<<SW) - N_STATE);

    ctl_e            ctl;
    logic [AW-1:0]   ptr;
    logic [SW-1:0]   cur_state;
    logic [EW-1:0]   rd_entry;
    logic [N_OUT-1:0] nxt_out;
    logic [SW-1:0]   nxt_raw;
    logic [SW-1:0]   nxt_state;
    logic            cfg_fire;
    logic            fire;
    logic            last;
    logic            illegal;

    assign cfg_ready = ctl == CFG;
    assign running   = ctl == RUN;
    assign in_ready  = running && (!out_valid || out_ready);
    assign fire      = in_valid && in_ready && !cfg_restart;
    assign cfg_fire  = cfg_valid && cfg_ready && !cfg_restart;
    assign last      = ptr == AW'(DEPTH - 1);
    assign nxt_out   = rd_entry[ENT_OUT_LSB +: N_OUT];
    assign nxt_raw   = rd_entry[ENT_OUT_LSB + N_OUT +: SW];
    assign illegal   = !LEGAL[nxt_raw];
    assign nxt_state = illegal ? RST_S : nxt_raw;

    kiss_fsm_table #(.AW(AW), .DEPTH(DEPTH), .EW(EW)) u_table (
        .clk   (clk),
        .we    (cfg_fire),
        .waddr (ptr),
        .wdata (cfg_data),
        .raddr ({cur_state, in_data}),
        .rdata (rd_entry)
    );

    // Controller, load pointer, FSM state and registered result; restart beats a same-cycle fire
    always_ff @(posedge clk) begin
        if (rst) begin
            ctl       <= CFG;
            ptr       <= '0;
            cur_state <= RST_S;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_state <= RST_S;
            err       <= 1'b0;
        end else if (cfg_restart) begin
            ctl       <= CFG;
            ptr       <= '0;
            cur_state <= RST_S;
            out_valid <= 1'b0;
        end else if (cfg_fire) begin
            ptr <= last ? '0 : ptr + AW'(1);
            ctl <= last ? RUN : CFG;
        end else if (fire) begin
            out_valid <= 1'b1;
            out_data  <= nxt_out;
            out_state <= nxt_state;
            cur_state <= nxt_state;
            err       <= err | illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef FSM_ACTIVITY_CNT_EN
    logic [32:0] act_sum;

    assign act_sum = {1'b0, act_count}
                   + 33'($countones(nxt_out ^ out_data))
                   + 33'($countones(nxt_state ^ cur_state));

    // Saturating toggle count per fire; clear has priority over a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || act_clr) act_count <= '0;
        else if (fire) act_count <= act_sum[32] ? '1 : act_sum[31:0];
    end
`endif

endmodule
